// File: rtl/data_repeater_pkg.sv
// Shared definitions for the data repeater arbiter.
//   - parameter defaults for word width, channel count and burst length
//   - arbiter state encoding
//   - channel-index width helper (at least one bit, even for tiny N_CH)
package data_repeater_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_N_CH   = 4;
  localparam int DEF_BURST  = 16;

  typedef enum logic {
    IDLE,
    GRANT
  } arb_state_e;

  function automatic int ch_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/repeater_skid_buf.sv
// Two-entry output buffer with same-cycle bypass.
// A word arriving on in_* can leave on out_* in the same cycle when the
// buffer is empty; otherwise it is stored behind the current head.
// Ports:
//   clk_i, reset_n_i   clock, synchronous active-low reset
//   in_valid_i/in_dat_i incoming word (landing source read)
//   out_ready_i        consumer accepts head this cycle
//   out_valid_o/out_dat_o head of queue (stored entry or bypassed input)
//   count_o            number of stored entries (0..2)
module repeater_skid_buf #(
  parameter int W = 34
) (
  input  logic         clk_i,
  input  logic         reset_n_i,
  input  logic         in_valid_i,
  input  logic [W-1:0] in_dat_i,
  input  logic         out_ready_i,
  output logic         out_valid_o,
  output logic [W-1:0] out_dat_o,
  output logic [1:0]   count_o
);

  logic [W-1:0] slot0;
  logic [W-1:0] slot1;
  logic [1:0]   cnt;
  logic         pop;
  logic         pop_stored;
  logic         push;
  logic         wr_slot1;

  always_comb begin
    out_valid_o = (cnt != 2'd0) || in_valid_i;
    out_dat_o   = (cnt != 2'd0) ? slot0 : in_dat_i;
    pop         = out_valid_o && out_ready_i;
    pop_stored  = pop && (cnt != 2'd0);
    // an incoming word consumed directly by the bypass is never stored
    push        = in_valid_i && !(pop && (cnt == 2'd0));
    // new word goes behind whatever remains after this cycle's pop
    wr_slot1    = pop_stored ? (cnt == 2'd2) : (cnt == 2'd1);
    count_o     = cnt;
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      cnt   <= '0;
      slot0 <= '0;
      slot1 <= '0;
    end else begin
      cnt <= cnt - {1'b0, pop_stored} + {1'b0, push};
      if (pop_stored) slot0 <= slot1;
      // a push into slot0 deliberately overrides the shift above
      if (push) begin
        if (wr_slot1) slot1 <= in_dat_i;
        else          slot0 <= in_dat_i;
      end
    end
  end

endmodule

// File: rtl/data_repeater_arb.sv
// Round-robin repeater: moves words from N_CH source FIFOs into one
// destination FIFO, up to BURST words per grant, tagging each word with
// its source channel.
// Ports:
//   clk_i, reset_n_i  clock, synchronous active-low reset
//   enable_i          permits new grants (drop ends the current grant)
//   ch_mask_i         per-channel enable
//   src_empty_i       source FIFO empty flags
//   src_dat_i         source data, channel k at [k*DATA_W +: DATA_W]
//   src_read_o        source read strobes (one-hot or zero)
//   dst_full_i        destination FIFO full
//   dst_write_o       destination write strobe
//   dst_dat_o         destination data
//   dst_ch_o          source channel of dst_dat_o
//   busy_o            granted, or words buffered / in flight
module data_repeater_arb
  import data_repeater_pkg::*;
#(
  parameter  int DATA_W = DEF_DATA_W,
  parameter  int N_CH   = DEF_N_CH,
  parameter  int BURST  = DEF_BURST,
  localparam int CH_W   = ch_width(N_CH)
) (
  input  logic                   clk_i,
  input  logic                   reset_n_i,
  input  logic                   enable_i,
  input  logic [N_CH-1:0]        ch_mask_i,
  input  logic [N_CH-1:0]        src_empty_i,
  input  logic [N_CH*DATA_W-1:0] src_dat_i,
  output logic [N_CH-1:0]        src_read_o,
  input  logic                   dst_full_i,
  output logic                   dst_write_o,
  output logic [DATA_W-1:0]      dst_dat_o,
  output logic [CH_W-1:0]        dst_ch_o,
  output logic                   busy_o
);

  localparam int          ENT_W  = DATA_W + CH_W;
  localparam int unsigned NCH_U  = N_CH;

  arb_state_e        state;
  logic [CH_W-1:0]   ch;
  logic [CH_W-1:0]   ptr;
  logic [7:0]        count;
  logic              infl;
  logic [CH_W-1:0]   infl_ch;

  logic [N_CH-1:0]   avail_vec;
  logic              found;
  logic [CH_W-1:0]   pick;
  logic [1:0]        buf_cnt;
  logic [1:0]        occ;
  logic              head_valid;
  logic [ENT_W-1:0]  head;
  logic [ENT_W-1:0]  land;
  logic              cur_ok;
  logic              room;
  logic              rd;
  logic              wr;
  logic              last;

  always_comb begin : rr_search
    int unsigned idx;
    avail_vec = ch_mask_i & ~src_empty_i;
    found     = 1'b0;
    pick      = '0;
    idx       = 0;
    for (int unsigned i = 1; i <= NCH_U; i++) begin
      idx = (32'(ptr) + i) % NCH_U;
      if (!found && avail_vec[CH_W'(idx)]) begin
        found = 1'b1;
        pick  = CH_W'(idx);
      end
    end
  end

  always_comb begin
    cur_ok      = ch_mask_i[ch] && !src_empty_i[ch] && enable_i;
    occ         = buf_cnt + {1'b0, infl};
    wr          = head_valid && !dst_full_i;
    // a full buffer may still accept a read when a word leaves this cycle
    room        = (occ != 2'd2) || wr;
    rd          = (state == GRANT) && cur_ok && room;
    last        = (count == 8'(BURST - 1));
    src_read_o  = rd ? (N_CH'(1) << ch) : '0;
    land        = {infl_ch, src_dat_i[int'(infl_ch) * DATA_W +: DATA_W]};
    dst_write_o = wr;
    dst_dat_o   = head_valid ? head[DATA_W-1:0] : '0;
    dst_ch_o    = head_valid ? head[ENT_W-1:DATA_W] : '0;
    busy_o      = (state == GRANT) || (occ != 2'd0);
  end

  repeater_skid_buf #(
    .W (ENT_W)
  ) u_buf (
    .clk_i       (clk_i),
    .reset_n_i   (reset_n_i),
    .in_valid_i  (infl),
    .in_dat_i    (land),
    .out_ready_i (!dst_full_i),
    .out_valid_o (head_valid),
    .out_dat_o   (head),
    .count_o     (buf_cnt)
  );

  // The grant ends on the cycle of its last read, so the next arbitration
  // happens in the immediately following cycle.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state   <= IDLE;
      ptr     <= CH_W'(N_CH - 1);
      ch      <= '0;
      count   <= '0;
      infl    <= 1'b0;
      infl_ch <= '0;
    end else begin
      infl <= rd;
      if (rd) infl_ch <= ch;
      case (state)
        IDLE: begin
          if (found && enable_i) begin
            state <= GRANT;
            ch    <= pick;
            count <= '0;
          end
        end
        GRANT: begin
          if (!cur_ok) begin
            state <= IDLE;
            ptr   <= ch;
          end else if (rd) begin
            count <= count + 8'd1;
            if (last) begin
              state <= IDLE;
              ptr   <= ch;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_repeater_arb.sv
// Directed bench for data_repeater_arb (DATA_W=32, N_CH=4, BURST=4).
// Source FIFOs are modelled as word counters; word k,i = A5_kk_iiii.
module tb_data_repeater_arb;

  localparam int DW = 32;
  localparam int NC = 4;
  localparam int BL = 4;
  localparam int CW = 2;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             enable;
  logic [NC-1:0]    ch_mask;
  logic [NC-1:0]    src_empty;
  logic [NC*DW-1:0] src_dat_bus;
  logic [NC-1:0]    src_read;
  logic             dst_full;
  logic             dst_write;
  logic [DW-1:0]    dst_dat;
  logic [CW-1:0]    dst_ch;
  logic             busy;

  int            avail  [NC];
  int            rd_idx [NC];
  int            exp_idx[NC];
  logic [DW-1:0] src_word[NC];
  int            cyc = 0;
  bit            bad_read = 1'b0;
  bit            bad_write = 1'b0;
  int            vectors = 0;
  int            miscompares = 0;

  typedef struct {
    int            cyc;
    int            ch;
    logic [DW-1:0] dat;
  } ev_t;
  ev_t rd_log[$];
  ev_t wr_log[$];

  int exp_off[12] = '{2, 3, 4, 5, 7, 8, 9, 10, 12, 13, 14, 15};
  int exp_ch [12] = '{1, 1, 1, 1, 2, 2, 2, 2, 1, 1, 1, 1};

  always #5 clk = ~clk;

  data_repeater_arb #(
    .DATA_W (DW),
    .N_CH   (NC),
    .BURST  (BL)
  ) dut (
    .clk_i       (clk),
    .reset_n_i   (reset_n),
    .enable_i    (enable),
    .ch_mask_i   (ch_mask),
    .src_empty_i (src_empty),
    .src_dat_i   (src_dat_bus),
    .src_read_o  (src_read),
    .dst_full_i  (dst_full),
    .dst_write_o (dst_write),
    .dst_dat_o   (dst_dat),
    .dst_ch_o    (dst_ch),
    .busy_o      (busy)
  );

  function automatic logic [DW-1:0] word(input int k, input int i);
    return 32'hA500_0000 | (32'(k) << 16) | (32'(i) & 32'h0000_FFFF);
  endfunction

  always_comb begin
    src_dat_bus = '0;
    src_empty   = '0;
    for (int k = 0; k < NC; k++) begin
      src_empty[k] = (rd_idx[k] >= avail[k]);
      src_dat_bus[k*DW +: DW] = src_word[k];
    end
  end

  // source FIFO model and destination monitor
  always @(posedge clk) begin
    for (int k = 0; k < NC; k++) begin
      if (src_read[k]) begin
        if (src_empty[k]) bad_read <= 1'b1;
        src_word[k] <= word(k, rd_idx[k]);
        rd_idx[k]   <= rd_idx[k] + 1;
        rd_log.push_back('{cyc + 1, k, 32'h0});
      end
    end
    if ($countones(src_read) > 1) bad_read <= 1'b1;
    if (dst_write) begin
      if (dst_full) bad_write <= 1'b1;
      wr_log.push_back('{cyc + 1, int'(dst_ch), dst_dat});
    end
    cyc <= cyc + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_logs();
    rd_log.delete();
    wr_log.delete();
  endtask

  task automatic check_writes(input string tag, input int n);
    chk({tag, "_nwrites"}, 64'(wr_log.size()), 64'(n));
    foreach (wr_log[i]) begin
      int c;
      c = wr_log[i].ch;
      chk({tag, "_data"}, 64'(wr_log[i].dat), 64'(word(c, exp_idx[c])));
      exp_idx[c]++;
    end
  endtask

  function automatic int n_rd(input int ch, input int lo, input int hi);
    int n = 0;
    foreach (rd_log[i])
      if ((ch < 0 || rd_log[i].ch == ch) && rd_log[i].cyc >= lo && rd_log[i].cyc <= hi) n++;
    return n;
  endfunction

  function automatic int n_wr(input int lo, input int hi);
    int n = 0;
    foreach (wr_log[i])
      if (wr_log[i].cyc >= lo && wr_log[i].cyc <= hi) n++;
    return n;
  endfunction

  initial begin
    int cyc0;
    int base;
    for (int k = 0; k < NC; k++) begin
      avail[k] = 0; rd_idx[k] = 0; exp_idx[k] = 0; src_word[k] = '0;
    end
    reset_n  = 1'b0;
    enable   = 1'b1;
    ch_mask  = '1;
    dst_full = 1'b0;
    avail[0] = 3;

    // held in reset with ch0 non-empty: everything quiet
    run(2);
    chk("rst_src_read",  64'(src_read),  64'(0));
    chk("rst_dst_write", 64'(dst_write), 64'(0));
    chk("rst_dst_dat",   64'(dst_dat),   64'(0));
    chk("rst_dst_ch",    64'(dst_ch),    64'(0));
    chk("rst_busy",      64'(busy),      64'(0));

    // ch0 with 3 words: grant, 3 back-to-back reads, writes one cycle later
    clear_logs();
    cyc0 = cyc;
    reset_n = 1'b1;
    run(10);
    chk("s1_nreads", 64'(rd_log.size()), 64'(3));
    foreach (rd_log[i]) begin
      chk("s1_rd_cycle", 64'(rd_log[i].cyc), 64'(cyc0 + 2 + i));
      chk("s1_rd_ch",    64'(rd_log[i].ch),  64'(0));
    end
    foreach (wr_log[i]) chk("s1_wr_cycle", 64'(wr_log[i].cyc), 64'(cyc0 + 3 + i));
    check_writes("s1", 3);
    chk("s1_busy_end", 64'(busy), 64'(0));

    // ch1 and ch2 with 10 words: bursts of 4 alternating, one idle cycle between
    clear_logs();
    cyc0 = cyc;
    avail[1] = 10;
    avail[2] = 10;
    run(40);
    chk("s2_nreads", 64'(rd_log.size()), 64'(20));
    for (int i = 0; i < 12 && i < rd_log.size(); i++) begin
      chk("s2_rd_cycle", 64'(rd_log[i].cyc), 64'(cyc0 + exp_off[i]));
      chk("s2_rd_ch",    64'(rd_log[i].ch),  64'(exp_ch[i]));
    end
    check_writes("s2", 20);

    // destination full for 5 cycles mid-stream on ch3
    clear_logs();
    cyc0 = cyc;
    avail[3] = 12;
    run(4);
    dst_full = 1'b1;
    run(2);
    chk("s3_stall_write", 64'(dst_write), 64'(0));
    chk("s3_stall_read",  64'(src_read),  64'(0));
    chk("s3_stall_busy",  64'(busy),      64'(1));
    run(3);
    dst_full = 1'b0;
    chk("s3_reads_to_full_end", 64'(n_rd(-1, cyc0, cyc0 + 9)), 64'(4));
    chk("s3_writes_while_full", 64'(n_wr(cyc0 + 5, cyc0 + 9)), 64'(0));
    run(25);
    check_writes("s3", 12);

    // ch0 masked but non-empty; ch3 served
    clear_logs();
    cyc0 = cyc;
    ch_mask  = 4'b1110;
    avail[0] = 8;
    avail[3] = 15;
    run(15);
    chk("s4_ch0_reads", 64'(n_rd(0, cyc0, cyc)), 64'(0));
    chk("s4_ch3_reads", 64'(n_rd(3, cyc0, cyc)), 64'(3));
    check_writes("s4", 3);

    // fill buffer (dst full), then reset for one cycle
    clear_logs();
    dst_full = 1'b1;
    ch_mask  = '1;
    run(6);
    chk("s5_fill_reads", 64'(rd_log.size()), 64'(2));
    chk("s5_fill_busy",  64'(busy),      64'(1));
    chk("s5_fill_write", 64'(dst_write), 64'(0));
    reset_n  = 1'b0;
    dst_full = 1'b0;
    run(1);
    reset_n = 1'b1;
    #1;
    chk("s5_post_write", 64'(dst_write), 64'(0));
    chk("s5_post_read",  64'(src_read),  64'(0));
    chk("s5_post_busy",  64'(busy),      64'(0));
    for (int k = 0; k < NC; k++) exp_idx[k] = rd_idx[k];
    clear_logs();
    run(20);
    check_writes("s5", avail[0] - exp_idx[0]);

    // enable dropped during a ch1 grant
    clear_logs();
    base = rd_idx[1];
    avail[1] = base + 6;
    run(3);
    enable = 1'b0;
    #1;
    chk("s6_drop_read",  64'(src_read),  64'(0));
    chk("s6_drop_write", 64'(dst_write), 64'(1));
    chk("s6_drop_ch",    64'(dst_ch),    64'(1));
    chk("s6_drop_dat",   64'(dst_dat),   64'(word(1, base + 1)));
    run(6);
    chk("s6_nreads", 64'(rd_log.size()), 64'(2));
    check_writes("s6", 2);
    chk("s6_busy_end", 64'(busy), 64'(0));

    chk("read_while_empty_or_multi", 64'(bad_read),  64'(0));
    chk("write_while_full",          64'(bad_write), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/data_repeater_arb.md
DATA_REPEATER_ARB -- requirements
Module: data_repeater_arb

Interface
REQ-001 SHALL have parameter DATA_W, default 32, word width.
REQ-002 SHALL have parameter N_CH, default 4, number of source FIFOs (2..16).
REQ-003 SHALL have parameter BURST, default 16, max words moved per grant (1..255).
REQ-004 SHALL derive CH_W = max(1, clog2(N_CH)); not user-settable.
REQ-005 SHALL have port clk_i  in  1  sole clock; one clock; all logic on rising edge.
REQ-006 SHALL have port reset_n_i  in  1  reset, synchronous, active-low.
REQ-007 SHALL have port enable_i  in  1  permits new grants.
REQ-008 SHALL have port ch_mask_i  in  N_CH  per-channel enable.
REQ-009 SHALL have port src_empty_i  in  N_CH  source FIFO empty flags.
REQ-010 SHALL have port src_dat_i  in  N_CH*DATA_W  source data; channel k at bits [k*DATA_W +: DATA_W].
REQ-011 SHALL have port src_read_o  out  N_CH  source read strobes, one-hot or zero.
REQ-012 SHALL have port dst_full_i  in  1  destination FIFO full.
REQ-013 SHALL have port dst_write_o  out  1  destination write strobe.
REQ-014 SHALL have port dst_dat_o  out  DATA_W  destination data.
REQ-015 SHALL have port dst_ch_o  out  CH_W  source channel of the word on dst_dat_o.
REQ-016 SHALL have port busy_o  out  1  high in GRANT or while buffered/in-flight words exist.

Function
REQ-017 SHALL treat sources as standard FIFOs: data valid on src_dat_i exactly one cycle after src_read_o.
REQ-018 SHALL never assert src_read_o[k] while src_empty_i[k]=1 (combinational gating).
REQ-019 SHALL hold a 2-entry output buffer; occ = stored entries + in-flight read (0..2).
REQ-020 SHALL issue a read only if occ<2, or occ=2 and a destination write occurs that cycle.
REQ-021 SHALL drive dst_write_o = buffer head valid AND NOT dst_full_i; never write while full.
REQ-022 SHALL sustain one word per cycle when source non-empty and destination not full.
REQ-023 SHALL have latency: src_read_o cycle N -> earliest dst_write_o cycle N+1.
REQ-024 SHALL preserve per-channel word order; dst_ch_o tags every word.
REQ-025 SHALL have FSM states IDLE, GRANT.
REQ-026 IDLE: search round-robin from ptr+1 (mod N_CH) for k with ch_mask_i[k]=1 and src_empty_i[k]=0; if found and enable_i=1 -> GRANT(k), word count cleared; else stay.
REQ-027 GRANT: leave to IDLE, ptr <= granted channel, when count reaches BURST, or src_empty_i[k]=1, or ch_mask_i[k]=0, or enable_i=0.
REQ-028 SHALL complete in-flight read into buffer on GRANT exit; no word lost or duplicated.
REQ-029 SHALL cost exactly one arbitration cycle (IDLE) between grants.
REQ-030 SHALL let a single active channel be re-granted after its burst (ptr wraps to it).
REQ-031 SHALL stall reads without loss when dst_full_i rises with occ=2 and an in-flight read.
REQ-032 SHALL restrict word count to 8 bits; it never wraps (bounded by BURST).

Reset
REQ-033 SHALL, on reset_n_i=0 at a clock edge: state IDLE, ptr = N_CH-1, count 0, buffer and in-flight cleared.
REQ-034 SHALL hold outputs at reset: src_read_o=0, dst_write_o=0, dst_dat_o=0, dst_ch_o=0, busy_o=0.
REQ-035 SHALL discard buffered and in-flight words on reset mid-operation; no write in the cycle after reset.

Structure
REQ-036 SHALL place state encoding and parameter defaults in shared package data_repeater_pkg.
REQ-037 SHALL implement the 2-entry buffer as sub-module repeater_skid_buf (DATA_W+CH_W wide).

Verification
REQ-038 Reset, ch0 holds 3 words, dst never full -> reads cycles 1-3 after grant, writes next cycle each, dst_ch_o=0.
REQ-039 BURST=4, ch1 and ch2 hold 10 words each -> 4 from ch1, 1 idle cycle, 4 from ch2, then ch1; order kept.
REQ-040 dst_full_i high 5 cycles mid-stream -> occ stays 2, no write while full, all words delivered once, in order.
REQ-041 ch_mask_i[0]=0 with ch0 non-empty -> ch0 never read; ch3 served.
REQ-042 reset_n_i low 1 cycle with occ=2 -> next cycle dst_write_o=0, src_read_o=0, busy_o=0.
REQ-043 enable_i drop during GRANT -> in-flight word written, then IDLE, no further reads.
